// File: rtl/idx_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idx_stream_reader_pkg
// Brief    : Shared constants and FSM state type for the index stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package idx_stream_reader_pkg;

    localparam int c_ADDR_W    = 16;
    localparam int c_BUF_WORDS = 2;
    localparam int c_LANES     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/idx_stream_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : idx_word_fifo
// Brief    : Shallow synchronous word FIFO with push/pop/occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module idx_word_fifo
    import idx_stream_reader_pkg::*;
#(
    parameter int DEPTH = c_BUF_WORDS,
    parameter int WIDTH = 32,
    localparam int CNT_BITS = $clog2(DEPTH + 1),
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [WIDTH-1:0]    i_push_data,
    input  logic                i_pop,
    output logic [WIDTH-1:0]    o_head,
    output logic                o_empty,
    output logic [CNT_BITS-1:0] o_count
);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_BITS-1:0] f_next(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/idx_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : idx_stream_reader
// Brief    : Reads a run of signed 8-bit indices from word SRAM, streams them.
// Revision : 1.0 - initial release
// ============================================================================
module idx_stream_reader
    import idx_stream_reader_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int CNT_W     = 17,
    parameter int BUF_WORDS = c_BUF_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [31:0]         sram_q,
    output logic signed [7:0]   idx_data,
    output logic                idx_valid,
    input  logic                idx_ready,
    output logic                idx_last
);

    localparam int c_FCNT_W = $clog2(BUF_WORDS + 1);
    localparam int c_OCC_W  = c_FCNT_W + 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_words_left;
    logic [CNT_W-1:0]    r_bytes_left;
    logic                r_pending;
    logic [1:0]          r_byte_sel;

    logic [31:0]         w_head;
    logic                w_empty;
    logic [c_FCNT_W-1:0] w_fifo_count;
    logic                w_valid;
    logic                w_xfer;
    logic                w_last;
    logic                w_word_end;
    logic                w_pop;
    logic                w_issue;
    logic [c_OCC_W-1:0]  w_occ;
    logic [CNT_W:0]      w_words_init;

    assign w_valid    = (r_state == ST_RUN) && !w_empty;
    assign w_xfer     = w_valid && idx_ready;
    assign w_last     = (r_bytes_left == CNT_W'(1));
    // A short final word ends early at the last byte of the run.
    assign w_word_end = (r_byte_sel == 2'd3) || w_last;
    assign w_pop      = w_xfer && w_word_end;

    // Slot freed by this cycle's pop can be reused by this cycle's issue.
    assign w_occ   = c_OCC_W'(w_fifo_count) + c_OCC_W'(r_pending) - c_OCC_W'(w_pop);
    assign w_issue = (r_state == ST_RUN) && (r_words_left != '0) &&
                     (w_occ < c_OCC_W'(BUF_WORDS));

    assign w_words_init = ({1'b0, count} + (CNT_W + 1)'(c_LANES - 1)) >> $clog2(c_LANES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_xfer && w_last) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == ST_RUN);
        done      = (r_state == ST_FIN);
        idx_valid = w_valid;
        idx_last  = w_valid && w_last;
        idx_data  = w_valid ? w_head[{r_byte_sel, 3'b000} +: 8] : 8'sd0;
        sram_wen  = 1'b0;
    end

    assign sram_addr = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_bytes_left <= '0;
            r_pending    <= 1'b0;
            r_byte_sel   <= '0;
        end else begin
            r_pending <= w_issue;
            if ((r_state == ST_IDLE) && start) begin
                r_addr       <= base_addr;
                r_words_left <= CNT_W'(w_words_init);
                r_bytes_left <= count;
                r_byte_sel   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + ADDR_W'(c_LANES);
                    r_words_left <= r_words_left - 1'b1;
                end
                if (w_xfer) begin
                    r_bytes_left <= r_bytes_left - 1'b1;
                    r_byte_sel   <= w_word_end ? 2'd0 : r_byte_sel + 2'd1;
                end
            end
        end
    end

    // SRAM data lands one cycle after the issue, exactly when r_pending is set.
    idx_word_fifo #(
        .DEPTH (BUF_WORDS),
        .WIDTH (32)
    ) u_word_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_pending),
        .i_push_data (sram_q),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_fifo_count)
    );

endmodule
`default_nettype wire
